common_dffram_wrarb: RTL and testbench
======================================

COMMON_DFFRAM_WRARB -- requirements
Module: common_dffram_wrarb

Interface
REQ-001 SHALL have parameter RAM_DATA_WIDTH, default 1, the word width of the attached DFF RAM.
REQ-002 SHALL have parameter RAM_ADDR_WIDTH, default 1, the attached RAM address width; depth is 2^RAM_ADDR_WIDTH.
REQ-003 SHALL have port clk, input, 1, the single clock; all state on rising edge.
REQ-004 SHALL have port reset, input, 1; one clock; reset is asynchronous and active-low.
REQ-005 SHALL have ports req0_valid in 1, req0_ready out 1, req0_addr in RAM_ADDR_WIDTH, req0_data in RAM_DATA_WIDTH: write requester 0.
REQ-006 SHALL have ports req1_valid, req1_ready, req1_addr, req1_data, same directions and widths: write requester 1.
REQ-007 SHALL have ports clear_start in 1 (clear request pulse), clear_busy out 1, clear_done out 1 (one-cycle pulse).
REQ-008 SHALL have ports ram_addra out RAM_ADDR_WIDTH, ram_ena out 1, ram_wea out 1, ram_dina out RAM_DATA_WIDTH, driving RAM port A.

Function
REQ-009 SHALL accept a write on requester n when reqn_valid & reqn_ready are high at a rising clk edge.
REQ-010 SHALL drive req0_ready/req1_ready combinationally: only the granted requester is ready; both 0 while clear_busy.
REQ-011 SHALL grant by round-robin when both valid: grant goes to the requester not granted in the last accepted transfer; after reset requester 0 has priority.
REQ-012 SHALL grant a lone valid requester immediately, regardless of priority pointer.
REQ-013 SHALL update the priority pointer only on an accepted transfer.
REQ-014 SHALL register the accepted write: ram_ena=ram_wea=1, ram_addra/ram_dina = accepted addr/data in the cycle after acceptance (1-cycle latency), else ram_ena=ram_wea=0.
REQ-015 SHALL sustain one accepted write per cycle (back-to-back, alternating under contention).
REQ-016 SHALL hold ram_addra/ram_dina at last value when no write issues.
REQ-017 SHALL implement FSM IDLE -> CLEAR on clear_start in IDLE; CLEAR -> IDLE after writing address 2^RAM_ADDR_WIDTH-1.
REQ-018 SHALL in CLEAR write all-zero data to addresses 0,1,...,depth-1, one per cycle, via the same registered outputs; clear_busy=1 throughout CLEAR.
REQ-019 SHALL pulse clear_done one cycle, coincident with the cycle the last clear write is presented on the RAM outputs.
REQ-020 SHALL ignore clear_start while in CLEAR; a clear_start coincident with requester valid takes precedence (no request accepted that cycle).
REQ-021 SHALL wrap the clear address counter to 0 on completion without overflow artefacts.

Reset
REQ-022 SHALL on reset low, immediately: state IDLE, pointer to requester 0, clear counter 0, ram_ena=ram_wea=0, ram_addra=0, ram_dina=0, clear_busy=0, clear_done=0.
REQ-023 SHALL abort an in-progress clear on reset mid-operation with no further writes issued.

Configuration
REQ-024 SHALL compile the clear sequencer only when COMMON_DFFRAM_WRARB_CLEAR_EN is defined.
REQ-025 SHALL without COMMON_DFFRAM_WRARB_CLEAR_EN keep the ports, ignore clear_start, tie clear_busy=0 and clear_done=0, and contain no CLEAR state.

Structure
REQ-026 SHALL place FSM state encodings (IDLE, CLEAR) and the grant-index constants in shared package common_dffram_pkg.
REQ-027 SHALL instantiate sub-module common_rr_arb2 (2-way round-robin with pointer update on accept) for grant generation.

Verification
REQ-028 SHALL cover: after reset, req0 addr 3 data 0xA5 valid -> next cycle ram_ena=ram_wea=1, ram_addra=3, ram_dina=0xA5.
REQ-029 SHALL cover: both valid 4 cycles -> grants 0,1,0,1, RAM writes in same order one per cycle.
REQ-030 SHALL cover: only req1 valid 3 cycles -> req1 accepted every cycle, req0_ready=0.
REQ-031 SHALL cover (CLEAR_EN, RAM_ADDR_WIDTH=2): clear_start -> four writes addr 0..3 data 0, clear_done with addr 3, readies 0 meanwhile, requests resume after.
REQ-032 SHALL cover: reset asserted during CLEAR at addr 1 -> outputs immediately reset values, no further writes, clear_busy=0.
REQ-033 SHALL cover: clear_start and req0_valid same cycle -> req0 not accepted, CLEAR entered.

Source files
------------

// File: rtl/common_dffram_pkg.sv
// Shared encodings for the DFF RAM write arbiter: sequencer states and grant indices.
package common_dffram_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  localparam logic GRANT_REQ0 = 1'b0;
  localparam logic GRANT_REQ1 = 1'b1;

endpackage

// File: rtl/common_rr_arb2.sv
// Two-way round-robin arbiter; the tie-break pointer moves only when a transfer is accepted.
module common_rr_arb2
  import common_dffram_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic valid0,
  input  logic valid1,
  input  logic enable,
  output logic ready0,
  output logic ready1,
  output logic accept,
  output logic grant
);

  // prio names the requester that wins the next tie
  logic prio;

  always_comb begin
    grant  = (valid1 && (!valid0 || prio == GRANT_REQ1)) ? GRANT_REQ1 : GRANT_REQ0;
    ready0 = enable && valid0 && (grant == GRANT_REQ0);
    ready1 = enable && valid1 && (grant == GRANT_REQ1);
    accept = ready0 || ready1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prio <= GRANT_REQ0;
    end else if (accept) begin
      prio <= (grant == GRANT_REQ0) ? GRANT_REQ1 : GRANT_REQ0;
    end
  end

endmodule

// File: rtl/common_dffram_wrarb.sv
// Write arbiter for a DFF RAM port A: two round-robin requesters plus an optional
// zero-fill sequencer compiled in with COMMON_DFFRAM_WRARB_CLEAR_EN.
module common_dffram_wrarb
  import common_dffram_pkg::*;
#(
  parameter int RAM_DATA_WIDTH = 1,
  parameter int RAM_ADDR_WIDTH = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req0_valid,
  output logic                      req0_ready,
  input  logic [RAM_ADDR_WIDTH-1:0] req0_addr,
  input  logic [RAM_DATA_WIDTH-1:0] req0_data,
  input  logic                      req1_valid,
  output logic                      req1_ready,
  input  logic [RAM_ADDR_WIDTH-1:0] req1_addr,
  input  logic [RAM_DATA_WIDTH-1:0] req1_data,
  input  logic                      clear_start,
  output logic                      clear_busy,
  output logic                      clear_done,
  output logic [RAM_ADDR_WIDTH-1:0] ram_addra,
  output logic                      ram_ena,
  output logic                      ram_wea,
  output logic [RAM_DATA_WIDTH-1:0] ram_dina
);

  localparam logic [RAM_ADDR_WIDTH-1:0] LAST_ADDR = '1;

  logic                      arb_enable;
  logic                      accept;
  logic                      grant;
  logic                      clear_write;
  logic                      clear_last;
  logic [RAM_ADDR_WIDTH-1:0] clear_cnt;

`ifdef COMMON_DFFRAM_WRARB_CLEAR_EN
  state_t state, state_next;

  assign clear_busy  = (state == ST_CLEAR);
  assign clear_write = (state == ST_CLEAR);
  assign clear_last  = clear_write && (clear_cnt == LAST_ADDR);
  // a start pulse in IDLE blocks requesters in that same cycle
  assign arb_enable  = (state == ST_IDLE) && !clear_start;

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (clear_start) state_next = ST_CLEAR;
      ST_CLEAR: if (clear_cnt == LAST_ADDR) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      clear_cnt <= '0;
    end else begin
      state     <= state_next;
      clear_cnt <= clear_write ? clear_cnt + 1'b1 : '0;
    end
  end
`else
  logic unused_clear_start;

  assign unused_clear_start = clear_start;
  assign clear_busy  = 1'b0;
  assign clear_write = 1'b0;
  assign clear_last  = 1'b0;
  assign clear_cnt   = '0;
  assign arb_enable  = 1'b1;
`endif

  common_rr_arb2 u_arb (
    .clk    (clk),
    .reset  (reset),
    .valid0 (req0_valid),
    .valid1 (req1_valid),
    .enable (arb_enable),
    .ready0 (req0_ready),
    .ready1 (req1_ready),
    .accept (accept),
    .grant  (grant)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ram_ena    <= 1'b0;
      ram_wea    <= 1'b0;
      ram_addra  <= '0;
      ram_dina   <= '0;
      clear_done <= 1'b0;
    end else begin
      ram_ena    <= 1'b0;
      ram_wea    <= 1'b0;
      clear_done <= clear_last;
      if (clear_write) begin
        ram_ena   <= 1'b1;
        ram_wea   <= 1'b1;
        ram_addra <= clear_cnt;
        ram_dina  <= '0;
      end else if (accept) begin
        ram_ena   <= 1'b1;
        ram_wea   <= 1'b1;
        ram_addra <= (grant == GRANT_REQ1) ? req1_addr : req0_addr;
        ram_dina  <= (grant == GRANT_REQ1) ? req1_data : req0_data;
      end
    end
  end

endmodule

// File: tb/tb_common_dffram_wrarb.sv
// Scoreboard bench for common_dffram_wrarb: driver predicts writes into a queue,
// a monitor pops and compares each RAM write presented by the design.
module tb_common_dffram_wrarb;

  localparam int DW    = 8;
  localparam int AW    = 2;
  localparam int DEPTH = 1 << AW;

  logic          clk;
  logic          rst_n;
  logic          req0_valid, req1_valid, clear_start;
  logic [AW-1:0] req0_addr, req1_addr;
  logic [DW-1:0] req0_data, req1_data;
  logic          req0_ready, req1_ready, clear_busy, clear_done;
  logic [AW-1:0] ram_addra;
  logic          ram_ena, ram_wea;
  logic [DW-1:0] ram_dina;

  common_dffram_wrarb #(.RAM_DATA_WIDTH(DW), .RAM_ADDR_WIDTH(AW)) dut (
    .clk         (clk),
    .reset       (rst_n),
    .req0_valid  (req0_valid),
    .req0_ready  (req0_ready),
    .req0_addr   (req0_addr),
    .req0_data   (req0_data),
    .req1_valid  (req1_valid),
    .req1_ready  (req1_ready),
    .req1_addr   (req1_addr),
    .req1_data   (req1_data),
    .clear_start (clear_start),
    .clear_busy  (clear_busy),
    .clear_done  (clear_done),
    .ram_addra   (ram_addra),
    .ram_ena     (ram_ena),
    .ram_wea     (ram_wea),
    .ram_dina    (ram_dina)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          done;
    int            cyc;
  } wr_t;

  wr_t           exp_q[$];
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            busy_left = 0;
  int            last_grant = 1;  // so requester 0 wins the first tie
  logic [AW-1:0] last_addr = '0;
  logic [DW-1:0] last_data = '0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks = checks + 1;
    if (act !== req) begin
      errors = errors + 1;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // monitor
  always @(posedge clk) begin
    wr_t e;
    #1;
    if (ram_ena) begin
      chk("wea_with_ena", ram_wea, 1);
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("write_cycle", cyc, e.cyc);
        chk("write_addr", ram_addra, e.addr);
        chk("write_data", ram_dina, e.data);
        chk("clear_done", clear_done, e.done);
        last_addr = e.addr;
        last_data = e.data;
      end
    end else begin
      chk("wea_idle", ram_wea, 0);
      chk("clear_done_idle", clear_done, 0);
      chk("hold_addr", ram_addra, last_addr);
      chk("hold_data", ram_dina, last_data);
      if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
        chk("missing_write", 0, 1);
        e = exp_q.pop_front();
      end
    end
  end

  task automatic step(input logic v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                      input logic v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                      input logic cs);
    logic r0, r1, busy;
    int   win;
    @(negedge clk);
    req0_valid = v0; req0_addr = a0; req0_data = d0;
    req1_valid = v1; req1_addr = a1; req1_data = d1;
    clear_start = cs;
    r0 = 0; r1 = 0; busy = 0;
    if (busy_left > 0) begin
      busy = 1;
      busy_left = busy_left - 1;
`ifdef COMMON_DFFRAM_WRARB_CLEAR_EN
    end else if (cs) begin
      for (int i = 0; i < DEPTH; i++)
        exp_q.push_back('{addr: AW'(i), data: '0, done: (i == DEPTH-1), cyc: cyc + 2 + i});
      busy_left = DEPTH;
`endif
    end else if (v0 || v1) begin
      if (v0 && v1) win = (last_grant == 0) ? 1 : 0;
      else          win = v1 ? 1 : 0;
      if (win == 0) begin
        r0 = 1;
        exp_q.push_back('{addr: a0, data: d0, done: 1'b0, cyc: cyc + 1});
      end else begin
        r1 = 1;
        exp_q.push_back('{addr: a1, data: d1, done: 1'b0, cyc: cyc + 1});
      end
      last_grant = win;
    end
    #1;
    chk("req0_ready", req0_ready, r0);
    chk("req1_ready", req1_ready, r1);
    chk("clear_busy", clear_busy, busy);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, '0, '0, 0, '0, '0, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ena"}, ram_ena, 0);
    chk({tag, "_wea"}, ram_wea, 0);
    chk({tag, "_addr"}, ram_addra, 0);
    chk({tag, "_data"}, ram_dina, 0);
    chk({tag, "_busy"}, clear_busy, 0);
    chk({tag, "_done"}, clear_done, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    req0_valid = 0; req1_valid = 0; clear_start = 0;
    req0_addr = '0; req1_addr = '0; req0_data = '0; req1_data = '0;
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // single write after reset
    step(1, 2'd3, 8'hA5, 0, '0, '0, 0);
    idle(1);
    // contention: alternates starting from the requester not last served
    for (int i = 0; i < 4; i++)
      step(1, AW'(i), 8'h10 + 8'(i), 1, AW'(3 - i), 8'h20 + 8'(i), 0);
    // lone requester 1 back-to-back
    for (int i = 0; i < 3; i++) step(0, '0, '0, 1, AW'(i), 8'h30 + 8'(i), 0);
    idle(1);

`ifdef COMMON_DFFRAM_WRARB_CLEAR_EN
    // clear with a coincident request, requests during busy, resume afterwards
    step(1, 2'd1, 8'h55, 0, '0, '0, 1);
    for (int i = 0; i < DEPTH; i++) step(1, 2'd2, 8'h66, 1, 2'd3, 8'h77, i == 1);
    step(1, 2'd2, 8'h88, 0, '0, '0, 0);
    idle(2);

    // reset while the clear is presenting address 1
    step(0, '0, '0, 0, '0, '0, 1);
    idle(2);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("abort");
    exp_q.delete();
    busy_left  = 0;
    last_grant = 1;
    last_addr  = '0;
    last_data  = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle(DEPTH + 1);
    step(1, 2'd2, 8'h3C, 1, 2'd1, 8'hC3, 0);
    idle(1);
`endif

    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 1), AW'($urandom), DW'($urandom),
           $urandom_range(0, 1), AW'($urandom), DW'($urandom),
           $urandom_range(0, 19) == 0);
    idle(DEPTH + 3);
    chk("queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
